// File: rtl/dyn_pkg.sv
// Shared types and constants for the dynamic-network receive port.
package dyn_pkg;

    localparam int DYN_DATA_W  = 64;
    localparam int DYN_LEN_LSB = 22;
    localparam int DYN_LEN_W   = 8;

    typedef logic [DYN_DATA_W-1:0] dyn_flit_t;

    typedef enum logic {
        HDR  = 1'b0,
        BODY = 1'b1
    } dyn_frame_e;

    // Number of body flits announced by a header flit.
    function automatic logic [DYN_LEN_W-1:0] dyn_hdr_len(input dyn_flit_t flit);
        return flit[DYN_LEN_LSB +: DYN_LEN_W];
    endfunction

endpackage

// File: rtl/dyn_rx_fifo.sv
// First-word-fall-through flit buffer with occupancy count and overflow detection.
module dyn_rx_fifo
    import dyn_pkg::*;
#(
    parameter int DATA_W = DYN_DATA_W,
    parameter int DEPTH  = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   wr_en,
    input  logic [DATA_W-1:0]      wr_data,
    input  logic                   rd_en,
    output logic [DATA_W-1:0]      rd_data,
    output logic                   valid,
    output logic [$clog2(DEPTH):0] count,
    output logic                   deq,
    output logic                   overflow_err
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] mem [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             ovf_q, ovf_d;
    logic             full, enq;

    assign valid        = (count_q != '0);
    assign full         = (count_q == CNT_W'(DEPTH));
    assign deq          = valid && rd_en;
    // A full buffer still accepts a flit when a slot frees in the same cycle.
    assign enq          = wr_en && (!full || deq);
    assign rd_data      = mem[rd_ptr_q];
    assign count        = count_q;
    assign overflow_err = ovf_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        if (enq) wr_ptr_d = wr_ptr_q + 1'b1;
        if (deq) rd_ptr_d = rd_ptr_q + 1'b1;
        case ({enq, deq})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        if (wr_en && !enq) ovf_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    // Storage holds data only; validity is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (enq) mem[wr_ptr_q] <= wr_data;
    end

endmodule

// File: rtl/dyn_rx_credit_port.sv
// Receive endpoint of one dynamic-network channel: buffering, credit return
// and packet framing (start/end of packet) on the dequeue side.
module dyn_rx_credit_port
    import dyn_pkg::*;
#(
    parameter int DATA_W  = DYN_DATA_W,
    parameter int DEPTH   = 4,
    parameter int LEN_LSB = DYN_LEN_LSB,
    parameter int LEN_W   = DYN_LEN_W
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [DATA_W-1:0]      data_in,
    input  logic                   valid_in,
    output logic                   yummy_out,
    output logic [DATA_W-1:0]      data_out,
    output logic                   valid_out,
    input  logic                   ready_in,
    output logic                   sop_out,
    output logic                   eop_out,
    output logic [$clog2(DEPTH):0] count_out,
    output logic                   overflow_err
);

    logic             deq;
    logic             yummy_q, yummy_d;
    dyn_frame_e       state_q, state_d;
    logic [LEN_W-1:0] rem_q, rem_d;
    logic [LEN_W-1:0] hdr_len;
    logic             eop_raw;

    dyn_rx_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk          (clk),
        .rst_n        (rst_n),
        .wr_en        (valid_in),
        .wr_data      (data_in),
        .rd_en        (ready_in),
        .rd_data      (data_out),
        .valid        (valid_out),
        .count        (count_out),
        .deq          (deq),
        .overflow_err (overflow_err)
    );

    assign hdr_len   = data_out[LEN_LSB +: LEN_W];
    assign yummy_out = yummy_q;
    // Head flit is undefined while empty, so keep eop low rather than echo it.
    assign eop_out   = valid_out && eop_raw;

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        sop_out = 1'b0;
        eop_raw = 1'b0;
        yummy_d = deq;
        case (state_q)
            HDR: begin
                sop_out = 1'b1;
                eop_raw = (hdr_len == '0);
                if (deq && (hdr_len != '0)) begin
                    rem_d   = hdr_len;
                    state_d = BODY;
                end
            end
            BODY: begin
                eop_raw = (rem_q == LEN_W'(1));
                if (deq) begin
                    rem_d = rem_q - 1'b1;
                    if (rem_q == LEN_W'(1)) state_d = HDR;
                end
            end
            default: state_d = HDR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= HDR;
            rem_q   <= '0;
            yummy_q <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            yummy_q <= yummy_d;
        end
    end

endmodule

// File: tb/tb_dyn_rx_credit_port.sv
// Directed and randomized bench for dyn_rx_credit_port against a queue-based model.
module tb_dyn_rx_credit_port;

    localparam int DEPTH   = 4;
    localparam int LEN_LSB = 22;

    logic        clk;
    logic        rst_n;
    logic [63:0] data_in;
    logic        valid_in;
    logic        yummy_out;
    logic [63:0] data_out;
    logic        valid_out;
    logic        ready_in;
    logic        sop_out;
    logic        eop_out;
    logic [2:0]  count_out;
    logic        overflow_err;

    dyn_rx_credit_port dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .data_in      (data_in),
        .valid_in     (valid_in),
        .yummy_out    (yummy_out),
        .data_out     (data_out),
        .valid_out    (valid_out),
        .ready_in     (ready_in),
        .sop_out      (sop_out),
        .eop_out      (eop_out),
        .count_out    (count_out),
        .overflow_err (overflow_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: queue of buffered flits, flits left in current packet.
    logic [63:0] mq[$];
    int          pkt_left;
    bit          m_ovf;
    bit          m_yummy;

    function automatic int flit_len(input logic [63:0] f);
        return int'((f >> LEN_LSB) & 64'hFF);
    endfunction

    function automatic logic [63:0] mk_hdr(input int len, input logic [63:0] low);
        return (64'(len) << LEN_LSB) | (low & 64'h3F_FFFF);
    endfunction

    function automatic logic [63:0] rnd_flit();
        logic [63:0] f;
        f = {$urandom, $urandom};
        f = (f & ~(64'hFF << LEN_LSB)) | (64'($urandom_range(0, 3)) << LEN_LSB);
        return f;
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp)
        else begin
            bad++;
            $error("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic check_outputs();
        logic exp_eop;
        chk("valid_out", 64'(valid_out), 64'(mq.size() > 0));
        chk("count_out", 64'(count_out), 64'(mq.size()));
        chk("overflow_err", 64'(overflow_err), 64'(m_ovf));
        chk("yummy_out", 64'(yummy_out), 64'(m_yummy));
        chk("sop_out", 64'(sop_out), 64'(pkt_left == 0));
        if (mq.size() > 0) begin
            chk("data_out", data_out, mq[0]);
            exp_eop = (pkt_left == 0) ? (flit_len(mq[0]) == 0) : (pkt_left == 1);
            chk("eop_out", 64'(eop_out), 64'(exp_eop));
        end
    endtask

    task automatic model_reset();
        mq.delete();
        pkt_left = 0;
        m_ovf    = 0;
        m_yummy  = 0;
    endtask

    // One clock: drive, check settled outputs, clock edge, advance the model.
    task automatic cycle(input logic v, input logic [63:0] d, input logic r);
        bit          deq;
        bit          was_full;
        logic [63:0] head;
        valid_in = v;
        data_in  = d;
        ready_in = r;
        #1;
        check_outputs();
        deq      = (mq.size() > 0) && r;
        was_full = (mq.size() == DEPTH);
        @(posedge clk);
        if (!rst_n) begin
            model_reset();
        end else begin
            if (deq) begin
                head = mq.pop_front();
                if (pkt_left == 0) pkt_left = flit_len(head);
                else pkt_left--;
            end
            if (v) begin
                if (!was_full || deq) mq.push_back(d);
                else m_ovf = 1;
            end
            m_yummy = deq;
        end
        #1;
    endtask

    int credits;
    bit v;

    initial begin
        // 1: reset held with traffic on the input
        rst_n    = 1'b0;
        valid_in = 1'b1;
        ready_in = 1'b0;
        data_in  = 64'hDEAD_BEEF_0000_0001;
        repeat (3) @(posedge clk);
        #1;
        chk("rst valid_out", 64'(valid_out), 64'd0);
        chk("rst yummy_out", 64'(yummy_out), 64'd0);
        chk("rst overflow_err", 64'(overflow_err), 64'd0);
        chk("rst count_out", 64'(count_out), 64'd0);
        chk("rst sop_out", 64'(sop_out), 64'd1);
        chk("rst eop_out", 64'(eop_out), 64'd0);
        model_reset();
        rst_n = 1'b1;

        // 2: header-only packet
        cycle(1'b1, 64'h0000_0000_0000_00A5, 1'b1);
        chk("hdr-only sop", 64'(sop_out), 64'd1);
        chk("hdr-only eop", 64'(eop_out), 64'd1);
        repeat (3) cycle(1'b0, 64'd0, 1'b1);

        // 3: header len=3 plus three bodies, streamed
        cycle(1'b1, mk_hdr(3, 64'h77), 1'b1);
        cycle(1'b1, 64'h11, 1'b1);
        cycle(1'b1, 64'h22, 1'b1);
        cycle(1'b1, 64'h33, 1'b1);
        repeat (3) cycle(1'b0, 64'd0, 1'b1);

        // 4: fill, then simultaneous enqueue/dequeue while full, then drain
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, mk_hdr(0, 64'(40 + i)), 1'b0);
        cycle(1'b1, mk_hdr(0, 64'h50), 1'b1);
        chk("full enq+deq count", 64'(count_out), 64'(DEPTH));
        repeat (DEPTH + 2) cycle(1'b0, 64'd0, 1'b1);

        // 5: overflow with ready low; fifth flit dropped, flag sticky
        for (int i = 0; i < DEPTH + 1; i++) cycle(1'b1, mk_hdr(0, 64'(60 + i)), 1'b0);
        chk("overflow flag", 64'(overflow_err), 64'd1);
        cycle(1'b0, 64'd0, 1'b0);
        repeat (DEPTH + 2) cycle(1'b0, 64'd0, 1'b1);

        // 6: reset in the middle of a packet
        cycle(1'b1, mk_hdr(5, 64'h5), 1'b1);
        cycle(1'b1, 64'hB1, 1'b1);
        cycle(1'b1, 64'hB2, 1'b1);
        cycle(1'b1, 64'hB3, 1'b0);
        rst_n = 1'b0;
        cycle(1'b0, 64'd0, 1'b0);
        rst_n = 1'b1;
        chk("mid-pkt rst count", 64'(count_out), 64'd0);
        chk("mid-pkt rst sop", 64'(sop_out), 64'd1);
        cycle(1'b1, mk_hdr(0, 64'hC0), 1'b0);
        cycle(1'b0, 64'd0, 1'b1);
        cycle(1'b0, 64'd0, 1'b1);

        // Longest legal packet: len=255
        cycle(1'b1, mk_hdr(255, 64'h9), 1'b1);
        for (int i = 0; i < 255; i++) cycle(1'b1, 64'(1000 + i), 1'b1);
        cycle(1'b1, mk_hdr(0, 64'hE), 1'b1);
        repeat (2) cycle(1'b0, 64'd0, 1'b1);

        // Randomized traffic from a credit-respecting sender
        credits = DEPTH;
        repeat (400) begin
            v = (credits > 0) && ($urandom_range(0, 3) != 0);
            if (v) credits--;
            cycle(v, rnd_flit(), 1'($urandom_range(0, 2) != 0));
            if (m_yummy) credits++;
        end

        // Randomized traffic that ignores credits
        repeat (300) begin
            cycle(1'($urandom_range(0, 1)), rnd_flit(), 1'($urandom_range(0, 2) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
